// File: rtl/rv32m_muldiv_unit_pkg.sv
// Shared RV32M definitions: funct3 operation codes, operand width and the
// divider iteration payload used between the unit and its step datapath.
package rv32m_muldiv_unit_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned MD_OP_WIDTH = 3;

  // funct3 encodings of the M-extension, aligned with the ALU op table
  localparam logic [MD_OP_WIDTH-1:0] MD_OP_MUL    = 3'd0;
  localparam logic [MD_OP_WIDTH-1:0] MD_OP_MULH   = 3'd1;
  localparam logic [MD_OP_WIDTH-1:0] MD_OP_MULHSU = 3'd2;
  localparam logic [MD_OP_WIDTH-1:0] MD_OP_MULHU  = 3'd3;
  localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIV    = 3'd4;
  localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIVU   = 3'd5;
  localparam logic [MD_OP_WIDTH-1:0] MD_OP_REM    = 3'd6;
  localparam logic [MD_OP_WIDTH-1:0] MD_OP_REMU   = 3'd7;

  // Partial remainder plus the shift register that starts as the dividend
  // and ends as the quotient
  typedef struct packed {
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
  } div_state_t;

  function automatic logic is_div_op(input logic [MD_OP_WIDTH-1:0] op);
    return (op == MD_OP_DIV) || (op == MD_OP_DIVU) ||
           (op == MD_OP_REM) || (op == MD_OP_REMU);
  endfunction

  function automatic logic is_signed_div(input logic [MD_OP_WIDTH-1:0] op);
    return (op == MD_OP_DIV) || (op == MD_OP_REM);
  endfunction

  function automatic logic is_rem_op(input logic [MD_OP_WIDTH-1:0] op);
    return (op == MD_OP_REM) || (op == MD_OP_REMU);
  endfunction

endpackage

// File: rtl/rv32m_div_step.sv
// One combinational restoring-division iteration.
//   i_cur     : current {rem, quo}; quo MSB is the next dividend bit
//   i_divisor : divisor magnitude
//   o_next    : {rem', quo'} with the new quotient bit shifted into quo LSB
module rv32m_div_step
  import rv32m_muldiv_unit_pkg::*;
(
  input  div_state_t      i_cur,
  input  logic [XLEN-1:0] i_divisor,
  output div_state_t      o_next
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Trial subtract; bit XLEN of the difference is the borrow
  always_comb begin
    shifted = {i_cur.rem, i_cur.quo[XLEN-1]};
    diff    = shifted - {1'b0, i_divisor};
    if (!diff[XLEN]) begin
      o_next.rem = diff[XLEN-1:0];
      o_next.quo = {i_cur.quo[XLEN-2:0], 1'b1};
    end else begin
      o_next.rem = shifted[XLEN-1:0];
      o_next.quo = {i_cur.quo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/rv32m_muldiv_unit.sv
// RV32M multiply/divide execution unit for the EX stage.
//   i_clk, i_rst_n            : clock, async active-low reset
//   i_valid, i_md_op          : M-type instruction present, funct3 operation
//   i_rs1_data, i_rs2_data    : forwarded operands
//   i_flush                   : abandon the operation in flight
//   o_stall                   : combinational hold request for IF/ID/EX
//   o_valid, o_result         : registered one-cycle result pulse
module rv32m_muldiv_unit
  import rv32m_muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  input  logic [MD_OP_WIDTH-1:0] i_md_op,
  input  logic [WIDTH-1:0]       i_rs1_data,
  input  logic [WIDTH-1:0]       i_rs2_data,
  input  logic                   i_flush,
  output logic                   o_stall,
  output logic                   o_valid,
  output logic [WIDTH-1:0]       o_result
);

  localparam int unsigned CNT_W  = $clog2(WIDTH);
  localparam int unsigned PROD_W = 2 * (WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [MD_OP_WIDTH-1:0] op_q;
  logic [WIDTH-1:0]       opa_q;     // multiplicand, or dividend/quotient shift reg
  logic [WIDTH-1:0]       opb_q;     // multiplier, or divisor magnitude
  logic [WIDTH-1:0]       rem_q;
  logic [CNT_W-1:0]       count_q;
  logic                   neg_quo_q;
  logic                   neg_rem_q;

  // Accept-time decode of the incoming instruction
  logic             accept;
  logic             in_div, in_sdiv, in_rem;
  logic             div_zero, div_ovf, div_special;
  logic [WIDTH-1:0] special_res, rs1_mag, rs2_mag;

  assign accept      = (state_q == S_IDLE) && i_valid && !i_flush;
  assign in_div      = is_div_op(i_md_op);
  assign in_sdiv     = is_signed_div(i_md_op);
  assign in_rem      = is_rem_op(i_md_op);
  assign div_zero    = (i_rs2_data == '0);
  assign div_ovf     = in_sdiv && (i_rs1_data == {1'b1, {(WIDTH-1){1'b0}}}) &&
                       (i_rs2_data == '1);
  assign div_special = in_div && (div_zero || div_ovf);
  assign rs1_mag     = (in_sdiv && i_rs1_data[WIDTH-1]) ? -i_rs1_data : i_rs1_data;
  assign rs2_mag     = (in_sdiv && i_rs2_data[WIDTH-1]) ? -i_rs2_data : i_rs2_data;

  // Divide-by-zero wins over overflow (overflow needs a nonzero divisor anyway)
  always_comb begin
    special_res = '0;
    if (div_zero) special_res = in_rem ? i_rs1_data : '1;
    else          special_res = in_rem ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
  end

  // Single 33x33 signed multiply; the extra bit selects signed/unsigned per operand
  logic                     mul_a_signed, mul_b_signed;
  logic signed [WIDTH:0]    mul_a, mul_b;
  logic signed [PROD_W-1:0] product;
  logic [WIDTH-1:0]         mul_res;
  logic                     unused_prod_hi;

  assign mul_a_signed   = (op_q != MD_OP_MULHU);
  assign mul_b_signed   = (op_q != MD_OP_MULHSU) && (op_q != MD_OP_MULHU);
  assign mul_a          = $signed({mul_a_signed & opa_q[WIDTH-1], opa_q});
  assign mul_b          = $signed({mul_b_signed & opb_q[WIDTH-1], opb_q});
  assign product        = PROD_W'(mul_a) * PROD_W'(mul_b);
  assign mul_res        = (op_q == MD_OP_MUL) ? product[WIDTH-1:0]
                                              : product[2*WIDTH-1:WIDTH];
  assign unused_prod_hi = ^product[PROD_W-1:2*WIDTH];

  // Divider iteration and final sign correction
  div_state_t       step_cur, step_nxt;
  logic [WIDTH-1:0] quo_fix, rem_fix, fix_res;

  assign step_cur.rem = rem_q;
  assign step_cur.quo = opa_q;

  rv32m_div_step u_div_step (
    .i_cur     (step_cur),
    .i_divisor (opb_q),
    .o_next    (step_nxt)
  );

  assign quo_fix = neg_quo_q ? -opa_q : opa_q;
  assign rem_fix = neg_rem_q ? -rem_q : rem_q;
  assign fix_res = is_rem_op(op_q) ? rem_fix : quo_fix;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state and stall request
  always_comb begin
    state_d = state_q;
    o_stall = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        o_stall = i_valid & ~o_valid;
        if (accept) begin
          if (!in_div)          state_d = S_MUL;
          else if (div_special) state_d = S_DONE;
          else                  state_d = S_DIV;
        end
      end
      S_MUL: begin
        o_stall = 1'b1;
        state_d = S_DONE;
      end
      S_DIV: begin
        o_stall = 1'b1;
        if (count_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        o_stall = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (i_flush) state_d = S_IDLE;
    if (!i_rst_n) o_stall = 1'b0;
  end

  // Operand latching, divider iteration and registered result
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      rem_q     <= '0;
      count_q   <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      o_valid   <= 1'b0;
      o_result  <= '0;
    end else begin
      o_valid <= (state_d == S_DONE);
      if (accept) begin
        op_q <= i_md_op;
        if (in_div) begin
          opa_q     <= rs1_mag;
          opb_q     <= rs2_mag;
          rem_q     <= '0;
          count_q   <= CNT_W'(WIDTH - 1);
          neg_quo_q <= in_sdiv & (i_rs1_data[WIDTH-1] ^ i_rs2_data[WIDTH-1]);
          neg_rem_q <= in_sdiv & i_rs1_data[WIDTH-1];
          if (div_special) o_result <= special_res;
        end else begin
          opa_q <= i_rs1_data;
          opb_q <= i_rs2_data;
        end
      end
      unique case (state_q)
        S_MUL: if (state_d == S_DONE) o_result <= mul_res;
        S_DIV: begin
          rem_q <= step_nxt.rem;
          opa_q <= step_nxt.quo;
          if (count_q != '0) count_q <= count_q - CNT_W'(1);
        end
        S_FIX: if (state_d == S_DONE) o_result <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Directed and randomized bench for rv32m_muldiv_unit with a result scoreboard.
module tb_rv32m_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic [2:0]  md_op;
  logic [31:0] rs1, rs2;
  logic        i_flush;
  logic        o_stall;
  logic        o_valid;
  logic [31:0] o_result;

  int          total  = 0;
  int          bad    = 0;
  int          pulses = 0;
  int          pushed = 0;
  logic [31:0] exp_q[$];

  logic [2:0]  r_op;
  logic [31:0] r_a, r_b;

  rv32m_muldiv_unit #(.WIDTH(32)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (i_valid),
    .i_md_op    (md_op),
    .i_rs1_data (rs1),
    .i_rs2_data (rs2),
    .i_flush    (i_flush),
    .o_stall    (o_stall),
    .o_valid    (o_valid),
    .o_result   (o_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && o_valid) pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model of the RV32M result semantics
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sbv, ua, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = longint'({32'h0, a});
    ub  = longint'({32'h0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 64'h0;
    case (op)
      3'd0: begin p = sa * sbv; return p[31:0];  end
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (ovf)        return 32'h8000_0000;
        return 32'($signed(a) / $signed(b));
      end
      3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'h0) return a;
        if (ovf)        return 32'h0;
        return 32'($signed(a) % $signed(b));
      end
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b);
    if (!op[2]) return 2;
    if (b == 32'h0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Issue one op, check stall each cycle, then latency and scoreboard result.
  // stall0=0 means the op is presented during a DONE cycle (accepted one cycle later).
  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat,
                       input bit stall0);
    int k;
    bit seen;
    md_op   = op;
    rs1     = a;
    rs2     = b;
    i_valid = 1'b1;
    exp_q.push_back(exp);
    pushed++;
    #1 chk({name, ":stall_c0"}, 32'(o_stall), 32'(stall0));
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 60) begin
      @(negedge clk);
      k++;
      if (o_valid) seen = 1'b1;
      else chk({name, ":stall_busy"}, 32'(o_stall), 32'h1);
      // Inputs change after accept; the unit must use its latched copies
      if (k == (stall0 ? 1 : 2)) begin
        rs1   = $urandom;
        rs2   = $urandom;
        md_op = 3'($urandom_range(0, 7));
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $error("FAIL %s:timeout observed=no_valid expected=valid_at_%0d", name, lat);
      void'(exp_q.pop_front());
    end else begin
      chk({name, ":latency"}, 32'(k), 32'(lat));
      chk({name, ":stall_done"}, 32'(o_stall), 32'h0);
      chk({name, ":result"}, o_result, exp_q.pop_front());
    end
    i_valid = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    i_valid = 1'b1;
    i_flush = 1'b0;
    md_op   = 3'd0;
    rs1     = 32'h0;
    rs2     = 32'h0;
    @(negedge clk);
    chk("reset:o_valid", 32'(o_valid), 32'h0);
    chk("reset:o_result", o_result, 32'h0);
    chk("reset:o_stall", 32'(o_stall), 32'h0);
    i_valid = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);

    // Multiply variants
    do_op("mulh_m1m1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2, 1'b1);
    @(negedge clk);
    do_op("mulhu_m1m1", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 1'b1);
    @(negedge clk);
    do_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, 1'b1);
    @(negedge clk);
    do_op("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1'b1);
    @(negedge clk);

    // Iterative divides
    do_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b1);
    @(negedge clk);
    do_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b1);
    @(negedge clk);
    do_op("divu_max_2", 3'd5, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 34, 1'b1);
    @(negedge clk);
    do_op("div_100_m7", 3'd4, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 34, 1'b1);
    @(negedge clk);
    do_op("rem_m100_7", 3'd6, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 34, 1'b1);
    @(negedge clk);
    do_op("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, 34, 1'b1);
    @(negedge clk);

    // Special cases
    do_op("divu_5_0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
    @(negedge clk);
    do_op("remu_5_0", 3'd7, 32'd5, 32'd0, 32'd5, 1, 1'b1);
    @(negedge clk);
    do_op("rem_m5_0", 3'd6, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1, 1'b1);
    @(negedge clk);
    do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b1);
    @(negedge clk);
    do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 1'b1);
    @(negedge clk);
    do_op("divu_nosp", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 34, 1'b1);
    @(negedge clk);

    // Flush in cycle 10 of a divide
    md_op   = 3'd4;
    rs1     = 32'd1000;
    rs2     = 32'd7;
    i_valid = 1'b1;
    repeat (10) @(negedge clk);
    chk("flush:stall_c10", 32'(o_stall), 32'h1);
    i_flush = 1'b1;
    i_valid = 1'b0;
    @(negedge clk);
    i_flush = 1'b0;
    #1 chk("flush:idle_stall", 32'(o_stall), 32'h0);
    do_op("flush:mul", 3'd0, 32'd6, 32'd7, 32'd42, 2, 1'b1);
    @(negedge clk);

    // Reset in cycle 5 of a divide
    md_op   = 3'd4;
    rs1     = 32'd12345;
    rs2     = 32'd7;
    i_valid = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid:o_valid", 32'(o_valid), 32'h0);
    chk("rst_mid:o_result", o_result, 32'h0);
    chk("rst_mid:o_stall", 32'(o_stall), 32'h0);
    @(negedge clk);
    i_valid = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    do_op("rst_after:divu", 3'd5, 32'd100, 32'd7, 32'd14, 34, 1'b1);
    @(negedge clk);

    // Back-to-back multiplies: second presented in the DONE cycle of the first
    do_op("b2b:first", 3'd0, 32'd3, 32'd5, 32'd15, 2, 1'b1);
    do_op("b2b:second", 3'd0, 32'd1234, 32'd5678, model(3'd0, 32'd1234, 32'd5678), 3, 1'b0);
    @(negedge clk);

    // Randomized mix, including zero divisors
    for (int i = 0; i < 12; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = (i % 4 == 0) ? 32'h0 : ((i % 4 == 1) ? 32'($urandom_range(1, 9)) : $urandom);
      do_op("rnd", r_op, r_a, r_b, model(r_op, r_a, r_b), lat_of(r_op, r_a, r_b), 1'b1);
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("pulse_count", 32'(pulses), 32'(pushed));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32m_muldiv_unit.md
# rv32m_muldiv_unit

Multi-cycle execution unit for the RV32M extension: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. It sits in the EX stage beside the combinational integer ALU. It takes the forwarded rs1/rs2 operands and sequences a registered multiply or an iterative radix-2 divide. While an operation is in flight it asserts a stall so the hazard unit freezes IF/ID/EX.

## Interface
Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.

Ports:
- i_clk  in  1  clock. The block uses one clock; all state changes on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  EX stage holds an M-extension instruction.
- i_md_op  in  3  operation, encoded as funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- i_rs1_data  in  WIDTH  dividend or multiplicand, already forwarded.
- i_rs2_data  in  WIDTH  divisor or multiplier, already forwarded.
- i_flush  in  1  kill the in-flight operation (branch mispredict or trap).
- o_stall  out  1  pipeline must hold EX and all earlier stages.
- o_valid  out  1  o_result is valid this cycle (single-cycle pulse).
- o_result  out  WIDTH  result for writeback.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- Accept: an operation is accepted when state is IDLE, i_valid=1 and i_flush=0. Operands and op are latched on accept; later changes to the inputs are ignored.
- Multiply path: IDLE→MUL→DONE.
  - MUL registers the full 64-bit product of sign- or zero-extended 33-bit operands: signed×signed for MULH, signed×unsigned for MULHSU, unsigned×unsigned for MULHU.
  - MUL returns product[31:0]; the other three return product[63:32].
- Divide path: IDLE→DIV→FIX→DONE.
  - On accept: latch |rs1| and |rs2| (signed ops) or the raw values (unsigned ops), the quotient sign and the remainder sign, and set count=31.
  - DIV: one restoring step per cycle, 32 steps; leave DIV when count reaches 0.
  - FIX: negate quotient and/or remainder as required.
- Special cases skip straight from IDLE to DONE:
  - Divide by zero: quotient = 0xFFFF_FFFF; remainder = dividend.
  - Signed overflow (0x8000_0000 / 0xFFFF_FFFF): quotient = 0x8000_0000; remainder = 0.
- DONE: o_valid=1 and o_result is driven; the next state is IDLE unconditionally. No back-to-back accept happens from DONE.
- o_stall = i_valid & ~o_valid when IDLE; 1 in MUL, DIV and FIX; 0 in DONE. o_stall is forced to 0 while i_rst_n=0.
- Flush: i_flush=1 in any state sends the next state to IDLE with no o_valid. Flush beats accept when both occur in the same cycle.
- Reset (asynchronous, also mid-operation): state=IDLE, o_valid=0, o_result=0, count=0.
- o_result holds its last value outside DONE.

## Timing
- Accept happens at edge 0 (the IDLE cycle with i_valid).
- Multiply: o_valid in cycle 2; stall is asserted in cycles 0–1.
- Divide: DIV occupies cycles 1–32, FIX is cycle 33, o_valid is in cycle 34; stall is asserted in cycles 0–33.
- Special-case divide: o_valid in cycle 1.
- In the DONE cycle the pipeline advances. If the next instruction is also M-type, it sees IDLE one cycle later and is accepted then.
- o_stall is combinational from state and i_valid, with no input-to-output path other than i_valid and i_flush. o_valid and o_result are registered.

## Structure
- Shared decoder header: MD_OP_* funct3 macros and the MD_OP_WIDTH macro, next to the existing ALU_OP definitions.
- State enum is local to the module.
- Sub-module rv32m_div_step: combinational single restoring iteration. It takes {rem, quo, divisor} and returns {rem', quo'}, and is instantiated once.
- The multiply is a single 33×33 signed multiply, inferred as DSP.

## Test plan
- MULH 0xFFFF_FFFF × 0xFFFF_FFFF → o_result 0x0000_0000 at cycle 2; MULHU with the same operands → 0xFFFF_FFFE; MUL 7 × −3 → 0xFFFF_FFEB.
- DIV −7 / 2 → 0xFFFF_FFFD (−3) at cycle 34; REM with the same operands → 0xFFFF_FFFF (−1); DIVU 0xFFFF_FFFF / 2 → 0x7FFF_FFFF. o_stall stays high in cycles 0–33.
- DIVU 5 / 0 → 0xFFFF_FFFF at cycle 1; REMU 5 / 0 → 5; DIV 0x8000_0000 / −1 → 0x8000_0000; REM with the same operands → 0.
- i_flush in cycle 10 of a DIV → IDLE next cycle, o_valid never pulses, and a new MUL issued afterwards completes correctly.
- i_rst_n dropped in cycle 5 of a DIV → o_valid=0, o_result=0 and o_stall=0 immediately; normal operation resumes after release.
- Two back-to-back MULs: the first result is at cycle 2 and the second is accepted at cycle 3 with its result at cycle 5; the operands of the first are unaffected by input changes after accept.
